// File: rtl/led_pwm_pio_pkg.sv
// Shared constants for led_pwm_pio: register map, CTRL bit index and parameter limits.
`timescale 1ns/1ps
package led_pwm_pio_pkg;

  localparam logic [4:0] ADDR_CTRL     = 5'd0;
  localparam logic [4:0] ADDR_PRESCALE = 5'd1;
  localparam logic [4:0] ADDR_MASK     = 5'd2;
  localparam logic [4:0] ADDR_BLINK    = 5'd3;
  localparam logic [4:0] ADDR_DUTY0    = 5'd4;

  localparam int CTRL_EN_BIT = 0;
  localparam int PRESCALE_W  = 16;

  localparam int N_CH_MIN   = 1;
  localparam int N_CH_MAX   = 16;
  localparam int DUTY_W_MIN = 4;
  localparam int DUTY_W_MAX = 16;

  function automatic bit params_ok(input int n_ch, input int duty_w, input int mirror_ch);
    return (n_ch >= N_CH_MIN) && (n_ch <= N_CH_MAX) &&
           (duty_w >= DUTY_W_MIN) && (duty_w <= DUTY_W_MAX) &&
           (mirror_ch >= 0) && (mirror_ch < n_ch);
  endfunction

endpackage

// File: rtl/led_pwm_pio_timebase.sv
// Shared PWM timebase: prescaler tick, period counter and (LED_PWM_PIO_BLINK_EN) blink phase.
`timescale 1ns/1ps
module led_pwm_pio_timebase
  import led_pwm_pio_pkg::*;
#(
  parameter int DUTY_W    = 8,
  parameter int BLINK_DIV = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick,
  output logic                  period_end,
  output logic [DUTY_W-1:0]     pcnt,
  output logic                  blink_phase
);

  // The period counter stops one short of all-ones so a full-scale duty is always high.
  localparam logic [DUTY_W-1:0] PCNT_LAST = DUTY_W'((1 << DUTY_W) - 2);

  logic [PRESCALE_W-1:0] pre_cnt;

  assign tick       = (pre_cnt >= prescale);
  assign period_end = tick && (pcnt == PCNT_LAST) && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pcnt    <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
      pcnt    <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
      end
    end
  end

`ifdef LED_PWM_PIO_BLINK_EN
  localparam int BCW = $clog2(BLINK_DIV + 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

  logic [BCW-1:0] blink_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (period_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_blink_div = BLINK_DIV;
  assign blink_phase = 1'b1;
`endif

endmodule

// File: rtl/led_pwm_pio.sv
// N-channel dimmable LED port on an Avalon-MM slave; LED_PWM_PIO_BLINK_EN adds per-channel blink.
`timescale 1ns/1ps
module led_pwm_pio
  import led_pwm_pio_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int DUTY_W    = 8,
  parameter int MIRROR_CH = 0,
  parameter int BLINK_DIV = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [4:0]      avs_address,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  input  logic            avs_read,
  output logic [31:0]     avs_readdata,
  output logic [N_CH-1:0] led,
  output logic            led_mirror
);

  if (!params_ok(N_CH, DUTY_W, MIRROR_CH)) begin : g_bad_params
    $fatal(1, "led_pwm_pio: N_CH, DUTY_W or MIRROR_CH out of range");
  end

  logic                             ctrl_en;
  logic [PRESCALE_W-1:0]            prescale;
  logic [N_CH-1:0]                  mask;
  logic [N_CH-1:0]                  blink;
  logic [N_CH-1:0]                  blink_ok;
  logic [N_CH-1:0]                  raw;
  logic [N_CH-1:0][DUTY_W-1:0]      duty_sel;
  logic [31:0]                      rd_mux;
  logic                             prescale_wr;
  logic                             tick;
  logic                             period_end;
  logic                             blink_phase;
  logic [DUTY_W-1:0]                pcnt;
  logic                             unused_bits;

  assign prescale_wr = avs_write && (avs_address == ADDR_PRESCALE);
  assign unused_bits = ^{avs_writedata, tick};

  led_pwm_pio_timebase #(
    .DUTY_W    (DUTY_W),
    .BLINK_DIV (BLINK_DIV)
  ) u_timebase (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (prescale_wr),
    .prescale    (prescale),
    .tick        (tick),
    .period_end  (period_end),
    .pcnt        (pcnt),
    .blink_phase (blink_phase)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en  <= 1'b0;
      prescale <= '0;
      mask     <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_CTRL:     ctrl_en  <= avs_writedata[CTRL_EN_BIT];
        ADDR_PRESCALE: prescale <= avs_writedata[PRESCALE_W-1:0];
        ADDR_MASK:     mask     <= avs_writedata[N_CH-1:0];
        default:       ;
      endcase
    end
  end

`ifdef LED_PWM_PIO_BLINK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink <= '0;
    end else if (avs_write && (avs_address == ADDR_BLINK)) begin
      blink <= avs_writedata[N_CH-1:0];
    end
  end
`else
  assign blink = '0;
`endif

  // Without the blink build blink is zero and blink_phase is tied high, so blink_ok is all ones.
  assign blink_ok = ~blink | {N_CH{blink_phase}};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [4:0] ADDR_I = ADDR_DUTY0 + 5'(i);

    logic [DUTY_W-1:0] duty_sh;
    logic [DUTY_W-1:0] duty_act;

    // Active duty only changes at a period boundary (or freely while disabled) to avoid runt pulses.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        duty_sh  <= '0;
        duty_act <= '0;
      end else begin
        if (avs_write && (avs_address == ADDR_I)) begin
          duty_sh <= avs_writedata[DUTY_W-1:0];
        end
        if (!ctrl_en || period_end) begin
          duty_act <= duty_sh;
        end
      end
    end

    assign raw[i]      = (pcnt < duty_act);
    assign duty_sel[i] = (avs_address == ADDR_I) ? duty_sh : '0;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL:     rd_mux[CTRL_EN_BIT]    = ctrl_en;
      ADDR_PRESCALE: rd_mux[PRESCALE_W-1:0] = prescale;
      ADDR_MASK:     rd_mux[N_CH-1:0]       = mask;
      ADDR_BLINK:    rd_mux[N_CH-1:0]       = blink;
      default: begin
        for (int i = 0; i < N_CH; i++) begin
          rd_mux[DUTY_W-1:0] = rd_mux[DUTY_W-1:0] | duty_sel[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led <= '0;
    end else begin
      led <= {N_CH{ctrl_en}} & mask & raw & blink_ok;
    end
  end

  assign led_mirror = led[MIRROR_CH];

endmodule

// File: tb/tb_led_pwm_pio.sv
// Scoreboard bench for led_pwm_pio: reads, LED samples and PWM pulse widths are checked by a monitor.
`timescale 1ns/1ps
module tb_led_pwm_pio;
  import led_pwm_pio_pkg::*;

  localparam int N_CH      = 8;
  localparam int DUTY_W    = 8;
  localparam int MIRROR_CH = 0;
  localparam int BLINK_DIV = 2;

  localparam int K_LED    = 0;
  localparam int K_LED0   = 1;
  localparam int K_MIRROR = 2;
  localparam int K_RDATA  = 3;

`ifdef LED_PWM_PIO_BLINK_EN
  localparam logic [31:0] BLINK_RD_EXP = 32'h0000_00FF;
`else
  localparam logic [31:0] BLINK_RD_EXP = 32'h0000_0000;
`endif

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } item_t;

  logic            clk;
  logic            reset_n;
  logic [4:0]      avs_address;
  logic            avs_write;
  logic [31:0]     avs_writedata;
  logic            avs_read;
  logic [31:0]     avs_readdata;
  logic [N_CH-1:0] led;
  logic            led_mirror;

  item_t rd_q[$];
  item_t samp_q[$];
  int    hi_q[$];
  int    per_q[$];

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    pulse_en = 0;
  logic  rd_pending = 0;

  item_t       it;
  logic [31:0] act;
  logic        prev_led0 = 0;
  bit          seen_rise = 0;
  bit          hi_valid  = 0;
  int          since_rise = 0;
  int          hi_len = 0;

  led_pwm_pio #(
    .N_CH      (N_CH),
    .DUTY_W    (DUTY_W),
    .MIRROR_CH (MIRROR_CH),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .led           (led),
    .led_mirror    (led_mirror)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Read data is valid the cycle after the strobe was sampled.
  always @(posedge clk) rd_pending <= avs_read;

  always @(negedge clk) begin
    if (rd_pending) begin
      if (rd_q.size() > 0) begin
        it = rd_q.pop_front();
        checkOutput(it.name, avs_readdata, it.exp);
      end else begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_read: got 0x%0h with no expectation queued", avs_readdata);
      end
    end

    while (samp_q.size() > 0) begin
      it = samp_q.pop_front();
      case (it.kind)
        K_LED:    act = 32'(led);
        K_LED0:   act = {31'b0, led[0]};
        K_MIRROR: act = {31'b0, led_mirror};
        default:  act = avs_readdata;
      endcase
      checkOutput(it.name, act, it.exp);
    end

    // Pulse monitor on led[0]: high-run length at each fall, rise-to-rise distance at each rise.
    if (pulse_en && reset_n) begin
      since_rise++;
      if (led[0] && !prev_led0) begin
        if (seen_rise && per_q.size() > 0) checkOutput("pwm_period", 32'(since_rise), 32'(per_q.pop_front()));
        seen_rise  = 1;
        since_rise = 0;
        hi_valid   = 1;
        hi_len     = 0;
      end
      if (led[0]) hi_len++;
      if (!led[0] && prev_led0 && hi_valid) begin
        if (hi_q.size() > 0) checkOutput("pwm_high", 32'(hi_len), 32'(hi_q.pop_front()));
        hi_valid = 0;
      end
    end else begin
      seen_rise  = 0;
      hi_valid   = 0;
      since_rise = 0;
      hi_len     = 0;
    end
    prev_led0 = led[0];
  end

  function automatic void push_samp(input int kind, input logic [31:0] exp, input string name);
    item_t x;
    x.name = name;
    x.kind = kind;
    x.exp  = exp;
    samp_q.push_back(x);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus cycle; a read pushes its expected data for the monitor.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [4:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rexp, input string name);
    item_t x;
    @(posedge clk);
    #1;
    avs_address   = addr;
    avs_write     = wr;
    avs_read      = rd;
    avs_writedata = wdata;
    if (rd) begin
      x.name = name;
      x.kind = K_RDATA;
      x.exp  = rexp;
      rd_q.push_back(x);
    end
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data, 32'h0, "");
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string name);
    applyStimulus(1'b0, 1'b1, addr, 32'h0, exp, name);
  endtask

  task automatic wait_led0(input logic val, input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (led[0] === val) return;
    end
    checkOutput(name, {31'b0, led[0]}, {31'b0, val});
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      if (hi_q.size() == 0 && per_q.size() == 0) return;
      idle(1);
    end
    checkOutput(name, 32'(hi_q.size() + per_q.size()), 32'd0);
    hi_q.delete();
    per_q.delete();
  endtask

  initial begin
    reset_n       = 1'b0;
    avs_address   = '0;
    avs_write     = 1'b0;
    avs_read      = 1'b0;
    avs_writedata = '0;

    idle(2);
    push_samp(K_LED,    32'h0, "reset_led");
    push_samp(K_MIRROR, 32'h0, "reset_mirror");
    push_samp(K_RDATA,  32'h0, "reset_rdata");
    idle(2);
    reset_n = 1'b1;
    idle(2);
    rd(ADDR_CTRL, 32'h0, "ctrl_after_reset");

    $display("[TB] duty 128 at prescale 0");
    wr(ADDR_MASK, 32'hFF);
    wr(ADDR_DUTY0, 32'd128);
    wr(ADDR_CTRL, 32'h1);
    rd(ADDR_DUTY0, 32'd128, "duty0_readback");
    wait_led0(1'b0, 300, "wait_low_d128");
    pulse_en = 1;
    hi_q.push_back(128);  hi_q.push_back(128);
    per_q.push_back(255); per_q.push_back(255);
    wait_drain(900, "drain_d128");
    pulse_en = 0;

    $display("[TB] duty 0 and full-scale duty");
    wr(ADDR_DUTY0, 32'd0);
    idle(300);
    for (int i = 0; i < 260; i++) begin
      push_samp(K_LED0, 32'h0, "duty0_never_high");
      idle(1);
    end
    wr(ADDR_DUTY0, 32'd255);
    idle(300);
    push_samp(K_MIRROR, 32'h1, "mirror_full");
    for (int i = 0; i < 260; i++) begin
      push_samp(K_LED0, 32'h1, "duty255_always_high");
      idle(1);
    end

    $display("[TB] mid-period duty change 64 -> 192");
    wr(ADDR_DUTY0, 32'd64);
    idle(300);
    wait_led0(1'b0, 300, "wait_low_d64");
    pulse_en = 1;
    hi_q.push_back(64);   hi_q.push_back(192); hi_q.push_back(192);
    per_q.push_back(255); per_q.push_back(255);
    wait_led0(1'b1, 300, "wait_rise_d64");
    idle(10);
    wr(ADDR_DUTY0, 32'd192);
    wait_drain(900, "drain_d64_192");
    pulse_en = 0;

    $display("[TB] prescale 3 and mask clear");
    wr(ADDR_PRESCALE, 32'd3);
    wait_led0(1'b0, 1100, "wait_low_ps3");
    pulse_en = 1;
    hi_q.push_back(768);   hi_q.push_back(768);
    per_q.push_back(1020);
    wait_drain(3300, "drain_ps3");
    pulse_en = 0;
    wait_led0(1'b1, 1100, "wait_high_ps3");
    idle(5);
    wr(ADDR_MASK, 32'hFE);
    push_samp(K_LED, 32'h01, "mask_before_effect");
    idle(1);
    push_samp(K_LED,    32'h00, "mask_cleared");
    push_samp(K_MIRROR, 32'h0,  "mask_cleared_mirror");

    $display("[TB] blink");
    wr(ADDR_PRESCALE, 32'd0);
    wr(ADDR_MASK, 32'hFF);
    wr(ADDR_DUTY0, 32'd255);
    wr(ADDR_BLINK, 32'h1);
    idle(600);
`ifdef LED_PWM_PIO_BLINK_EN
    wait_led0(1'b0, 1100, "wait_low_blink");
    pulse_en = 1;
    hi_q.push_back(510);   hi_q.push_back(510);
    per_q.push_back(1020); per_q.push_back(1020);
    wait_drain(3300, "drain_blink");
    pulse_en = 0;
`else
    rd(ADDR_BLINK, 32'h0, "blink_absent");
    for (int i = 0; i < 50; i++) begin
      push_samp(K_LED0, 32'h1, "no_blink_steady");
      idle(1);
    end
`endif

    $display("[TB] reset mid-run");
    wr(ADDR_BLINK, 32'h0);
    idle(2);
    rd(ADDR_MASK, 32'hFF, "mask_pre_reset");
    push_samp(K_LED0, 32'h1, "pre_reset_led");
    idle(1);
    reset_n = 1'b0;
    push_samp(K_LED,    32'h0, "midrun_reset_led");
    push_samp(K_MIRROR, 32'h0, "midrun_reset_mirror");
    push_samp(K_RDATA,  32'h0, "midrun_reset_rdata");
    idle(3);
    reset_n = 1'b1;
    idle(1);
    rd(ADDR_CTRL,     32'h0, "ctrl_cleared");
    rd(ADDR_PRESCALE, 32'h0, "prescale_cleared");
    rd(ADDR_MASK,     32'h0, "mask_cleared_reg");
    rd(ADDR_BLINK,    32'h0, "blink_cleared");
    rd(ADDR_DUTY0,    32'h0, "duty0_cleared");
    rd(5'd11,         32'h0, "duty7_cleared");

    $display("[TB] register readback with all-ones writes");
    wr(ADDR_CTRL,     32'hFFFF_FFFF);
    wr(ADDR_PRESCALE, 32'hFFFF_FFFF);
    wr(ADDR_MASK,     32'hFFFF_FFFF);
    wr(ADDR_BLINK,    32'hFFFF_FFFF);
    wr(ADDR_DUTY0,    32'hFFFF_FFFF);
    wr(5'd11,         32'hFFFF_FFFF);
    wr(5'd12,         32'hFFFF_FFFF);
    wr(5'd31,         32'hFFFF_FFFF);
    rd(ADDR_CTRL,     32'h0000_0001, "rb_ctrl");
    rd(ADDR_PRESCALE, 32'h0000_FFFF, "rb_prescale");
    rd(ADDR_MASK,     32'h0000_00FF, "rb_mask");
    rd(ADDR_BLINK,    BLINK_RD_EXP,  "rb_blink");
    rd(ADDR_DUTY0,    32'h0000_00FF, "rb_duty0");
    rd(5'd5,          32'h0000_0000, "rb_duty1_untouched");
    rd(5'd11,         32'h0000_00FF, "rb_duty7");
    rd(5'd12,         32'h0000_0000, "rb_unmapped12");
    rd(5'd31,         32'h0000_0000, "rb_unmapped31");
    applyStimulus(1'b1, 1'b1, ADDR_MASK, 32'h0F, 32'hFF, "rw_same_addr_old");
    idle(3);
    push_samp(K_RDATA, 32'hFF, "rdata_hold");
    idle(1);
    rd(ADDR_MASK, 32'h0F, "rw_same_addr_new");
    idle(3);

    if (rd_q.size() != 0 || samp_q.size() != 0) checkOutput("leftover_expectations", 32'(rd_q.size() + samp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_pio.md
# led_pwm_pio

- Parametrised successor to the HPS-driven LED output port: N independently dimmable channels.
- Each channel has its own duty register, a shared prescaled PWM timebase, an enable mask and optional blink.
- Written by the HPS over an Avalon-MM slave (lightweight bridge).
- Drives the board LEDs plus one mirrored channel routed to a GPIO_0 header pin.

## Interface
Parameters:
- N_CH, 8, number of LED channels (1..16)
- DUTY_W, 8, duty/period counter width (4..16)
- MIRROR_CH, 0, channel copied to led_mirror
- BLINK_DIV, 32, PWM periods per blink half-phase (blink build only)

Ports (reset is asynchronous, active-low):
- clk  in  1  system clock (50 MHz FPGA_CLK_50 domain)
- reset_n  in  1  asynchronous active-low reset
- avs_address  in  5  word address
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, registered
- led  out  N_CH  PWM outputs, registered
- led_mirror  out  1  equals led[MIRROR_CH]

## Operation
Register map (word addresses):
- 0 CTRL: bit0 global enable
- 1 PRESCALE: 16 bits
- 2 MASK: N_CH bits
- 3 BLINK: N_CH bits
- 4..4+N_CH-1 DUTY[i]: DUTY_W bits

Register behaviour:
- Unused or undriven bits read 0. Writes to unmapped addresses are ignored; reads from them return 0.
- Prescaler counts 0..PRESCALE, then emits a one-cycle tick and wraps. PRESCALE=0 gives a tick every clk.
- Writing PRESCALE clears the prescaler and the period counter.

PWM generation:
- Period counter advances on each tick over 0..2^DUTY_W-2 (period 2^DUTY_W-1 ticks).
- Its wrap is the period boundary.
- Channel raw output = (pcnt < duty_act[i]).
- DUTY=0 gives always low. DUTY=2^DUTY_W-1 gives always high.
- DUTY writes go to a shadow register. duty_act[i] loads from the shadow only at a period boundary (glitch-free dimming).
- While CTRL.0=0, duty_act loads continuously, so the first period after enable already uses the new value.

Output:
- led[i] = CTRL.0 & MASK[i] & raw[i] & blink_ok[i], registered.
- Simultaneous writes and period boundary in the same cycle: the boundary loads the old shadow, and the new shadow applies at the next boundary.
- Simultaneous read and write to the same address: readdata returns the pre-write value.

## Timing
- Write sampled at clk edge k updates the register at k. CTRL, MASK and BLINK changes appear on led at edge k+1.
- Read latency is 1 clock. avs_readdata is valid the cycle after avs_read and holds until the next read.
- No waitrequest: every access completes in one cycle.
- Reset (any time, including mid-period) clears all registers, counters, shadows, led, led_mirror and avs_readdata to 0 asynchronously. First tick comes on the first clk after reset_n deasserts, since PRESCALE=0.

## Configuration
LED_PWM_PIO_BLINK_EN:
- Defined:
  - Blink counter counts period boundaries modulo BLINK_DIV and toggles blink_phase at each wrap (blink_phase resets to 1).
  - blink_ok[i] = ~BLINK[i] | blink_phase.
  - Full blink cycle is 2·BLINK_DIV PWM periods.
- Undefined:
  - BLINK register is absent (address 3 reads 0, writes ignored).
  - blink_ok is all ones.
  - No blink counter is instantiated.

## Structure
- led_pwm_pio_pkg holds:
  - register address constants (ADDR_CTRL, ADDR_PRESCALE, ADDR_MASK, ADDR_BLINK, ADDR_DUTY0)
  - the CTRL bit index
  - DUTY_W/N_CH range-check constants
- One sub-module, led_pwm_pio_timebase, contains the prescaler, the period counter and the blink counter. Its outputs are pcnt, tick, period_end and blink_phase.
- Register file and per-channel comparators live in the top.

## Test plan
- Reset: hold reset_n=0 mid-run with led active → led=0, led_mirror=0, avs_readdata=0 immediately; all registers read 0 afterward.
- DUTY_W=8, PRESCALE=0, CTRL=1, MASK=0xFF, DUTY[0]=128 → led[0] high for exactly 128 of every 255 clks; DUTY 0 → never high; DUTY 255 → always high.
- Write DUTY[0] 64→192 mid-period → current period keeps a high time of 64; the next period has a high time of 192, with no runt pulse.
- PRESCALE=3 → PWM period = 4·255 = 1020 clks; clearing MASK bit 0 → led[0] low one clk after the write edge.
- Read each register after writing 0xFFFFFFFF → readdata valid one cycle after avs_read, with unused bits 0; unmapped address returns 0.
- With LED_PWM_PIO_BLINK_EN, BLINK_DIV=2, BLINK=1, DUTY[0]=255 → led[0] on for 510 clks, off for 510 clks, repeating; without the macro, BLINK reads 0 and led[0] stays on.
